// File: rtl/if_id_reg_if.sv
// ----------------------------------------------------------------------------
// if_id_reg_if
//
// Purpose : bundles the control and data signals that pass between the fetch
//           stage, the hazard unit and the IF/ID pipeline register.
//           Clock and reset are not part of the bundle and stay plain ports
//           on the register itself.
//
// Signals :
//   Enable     1  global run enable; 0 freezes the register
//   Stall      1  hazard-unit hold request for the D stage
//   Flush      1  replace the D-stage contents with a bubble
//   PC_F       32 address of the instruction fetched this cycle
//   Instr_F    32 instruction word fetched this cycle
//   PC_D       32 registered PC of the D-stage instruction
//   Instr_D    32 registered D-stage instruction
//   PC8_D      32 PC_D + 8 (link address)
//   Valid_D    1  D stage holds a real instruction
//   BD_D       1  D-stage instruction sits in a branch delay slot
//   Exc_D      1  fetch exception attached to the D-stage instruction
//   ExcCode_D  5  exception code of the D-stage instruction
//
// Modports:
//   master : the fetch/hazard side, which drives the F-stage inputs
//   slave  : the IF/ID register, which drives the D-stage outputs
// ----------------------------------------------------------------------------
interface if_id_reg_if;
    logic        Enable;
    logic        Stall;
    logic        Flush;
    logic [31:0] PC_F;
    logic [31:0] Instr_F;
    logic [31:0] PC_D;
    logic [31:0] Instr_D;
    logic [31:0] PC8_D;
    logic        Valid_D;
    logic        BD_D;
    logic        Exc_D;
    logic [4:0]  ExcCode_D;

    modport master (
        output Enable,
        output Stall,
        output Flush,
        output PC_F,
        output Instr_F,
        input  PC_D,
        input  Instr_D,
        input  PC8_D,
        input  Valid_D,
        input  BD_D,
        input  Exc_D,
        input  ExcCode_D
    );

    modport slave (
        input  Enable,
        input  Stall,
        input  Flush,
        input  PC_F,
        input  Instr_F,
        output PC_D,
        output Instr_D,
        output PC8_D,
        output Valid_D,
        output BD_D,
        output Exc_D,
        output ExcCode_D
    );
endinterface

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
//
// Purpose : IF/ID pipeline register of a MIPS-style five-stage pipeline.
//           Captures the fetched PC and instruction, tracks whether the D
//           stage holds a real instruction or a bubble, marks instructions
//           that sit in a branch delay slot, and optionally attaches a fetch
//           address exception (AdEL).
//
// Update priority on every rising Clock edge:
//   Reset (active low) > !Enable (hold) > Flush (bubble) > Stall (hold) > Load
//
// Ports:
//   Clock  1  single clock, all state changes on its rising edge
//   Reset  1  synchronous, active-low reset
//   bus       if_id_reg_if.slave -- Enable/Stall/Flush/PC_F/Instr_F in,
//             PC_D/Instr_D/PC8_D/Valid_D/BD_D/Exc_D/ExcCode_D out
//
// Parameters:
//   PC_RESET  PC presented on PC_D after reset
//   IM_BASE   lowest legal fetch byte address
//   IM_SIZE   size in bytes of the legal fetch window
//
// Configuration macro:
//   IF_ID_FETCH_EXC_EN -- when defined, a load from a misaligned PC or a PC
//   outside [IM_BASE, IM_BASE+IM_SIZE) is captured as an AdEL exception with
//   a zeroed instruction word. When undefined, Exc_D/ExcCode_D are always 0
//   and Instr_F is captured unconditionally.
// ----------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] PC_RESET = 32'h00003000,
    parameter logic [31:0] IM_BASE  = 32'h00003000,
    parameter logic [31:0] IM_SIZE  = 32'h00004000
) (
    input  logic        Clock,
    input  logic        Reset,
    if_id_reg_if.slave  bus
);

    localparam logic [4:0] EXC_ADEL = 5'd4;

`ifdef IF_ID_FETCH_EXC_EN
    localparam bit FETCH_EXC_EN = 1'b1;
`else
    localparam bit FETCH_EXC_EN = 1'b0;
`endif

    // The window limit is computed one bit wider so a window reaching the
    // top of the address space does not wrap around to a small value.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic        valid_q,    valid_d;
    logic        bd_q,       bd_d;
    logic        exc_q,      exc_d;
    logic [4:0]  exc_code_q, exc_code_d;

    logic        held_is_branch;
    logic        addr_bad;
    logic        fetch_exc;

    // Branch/jump decode of the instruction currently held in D. Opcodes
    // 1..7 cover REGIMM, j, jal, beq, bne, blez, bgtz; SPECIAL with funct
    // 8/9 covers jr and jalr. A zeroed (bubble or faulted) word decodes as
    // sll and is therefore never a branch.
    always_comb begin
        held_is_branch = 1'b0;
        unique case (instr_q[31:26])
            6'b000001, 6'b000010, 6'b000011, 6'b000100,
            6'b000101, 6'b000110, 6'b000111: held_is_branch = 1'b1;
            6'b000000: held_is_branch = (instr_q[5:0] == 6'b001000) ||
                                        (instr_q[5:0] == 6'b001001);
            default:   held_is_branch = 1'b0;
        endcase
    end

    // Fetch address check: misaligned, below the window or at/above its end.
    // Only turned into an exception when the feature is built in.
    always_comb begin
        addr_bad  = (bus.PC_F[1:0] != 2'b00) ||
                    (bus.PC_F < IM_BASE) ||
                    ({1'b0, bus.PC_F} >= IM_LIMIT);
        fetch_exc = FETCH_EXC_EN && addr_bad;
    end

    // Next-state selection. Everything defaults to hold, which covers both
    // !Enable and Stall; Flush is tested before Stall so it wins when both
    // are raised. The BD mark looks at the entry being replaced: a bubble
    // has valid_q=0, so a branch that was flushed never marks its successor.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        bd_d       = bd_q;
        exc_d      = exc_q;
        exc_code_d = exc_code_q;

        if (bus.Enable) begin
            if (bus.Flush) begin
                instr_d    = 32'h0;
                valid_d    = 1'b0;
                bd_d       = 1'b0;
                exc_d      = 1'b0;
                exc_code_d = 5'd0;
            end else if (!bus.Stall) begin
                pc_d       = bus.PC_F;
                instr_d    = fetch_exc ? 32'h0 : bus.Instr_F;
                valid_d    = 1'b1;
                bd_d       = valid_q && held_is_branch;
                exc_d      = fetch_exc;
                exc_code_d = fetch_exc ? EXC_ADEL : 5'd0;
            end
        end
    end

    // State register with synchronous active-low reset, which overrides
    // Enable, Stall and Flush on the same edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pc_q       <= PC_RESET;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            bd_q       <= 1'b0;
            exc_q      <= 1'b0;
            exc_code_q <= 5'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            bd_q       <= bd_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
        end
    end

    // Outputs come straight from the flops; the link address is a plain
    // 32-bit add whose carry out is dropped.
    always_comb begin
        bus.PC_D      = pc_q;
        bus.Instr_D   = instr_q;
        bus.PC8_D     = pc_q + 32'd8;
        bus.Valid_D   = valid_q;
        bus.BD_D      = bd_q;
        bus.Exc_D     = exc_q;
        bus.ExcCode_D = exc_code_q;
    end

endmodule
